// File: rtl/sd_host_registers_pkg.sv
// sd_host_registers_pkg
//   Shared definitions for the SD host register file and the Wishbone slave
//   in front of it: register word addresses, register widths and the
//   write-one-to-clear update used by the interrupt status registers.
package sd_host_registers_pkg;

  typedef enum logic [4:0] {
    REG_BLOCK_SIZE       = 5'h00,
    REG_BLOCK_COUNT      = 5'h01,
    REG_ARGUMENT         = 5'h02,
    REG_TRANSFER_MODE    = 5'h03,
    REG_COMMAND          = 5'h04,
    REG_RESPONSE         = 5'h05,
    REG_PRESENT_STATE    = 5'h06,
    REG_TIMEOUT_CONTROL  = 5'h07,
    REG_SOFTWARE_RESET   = 5'h08,
    REG_NORM_INT_STATUS  = 5'h09,
    REG_ERR_INT_STATUS   = 5'h0A
  } reg_addr_e;

  localparam int BLOCK_SIZE_W      = 12;
  localparam int BLOCK_COUNT_W     = 16;
  localparam int ARGUMENT_W        = 32;
  localparam int TRANSFER_MODE_W   = 16;
  localparam int COMMAND_W         = 16;
  localparam int RESPONSE_W        = 128;
  localparam int PRESENT_STATE_W   = 16;
  localparam int TIMEOUT_CONTROL_W = 16;
  localparam int SOFTWARE_RESET_W  = 3;
  localparam int INT_STATUS_W      = 16;

  // software_reset bit that returns the whole register file to reset values
  localparam int SWRST_ALL_BIT = 0;

  // Write-one-to-clear with set priority: a bit that is set and cleared in
  // the same cycle ends up set, so no event is ever lost.
  function automatic logic [INT_STATUS_W-1:0] w1c_next(
    input logic [INT_STATUS_W-1:0] status,
    input logic [INT_STATUS_W-1:0] clear_mask,
    input logic [INT_STATUS_W-1:0] set_in
  );
    return (status & ~clear_mask) | set_in;
  endfunction

endpackage

// File: rtl/sd_host_registers_if.sv
// sd_host_registers_if
//   Register access bus between the Wishbone slave (master modport) and the
//   register file (slave modport).
//     adr_i        register word address
//     reg_write_en one-cycle write strobe
//     reg_read_en  one-cycle read strobe
//     data_i       write data (registers use the low bits)
//     data_o       read data, valid one cycle after reg_read_en
interface sd_host_registers_if #(
  parameter int DATA_W = 128,
  parameter int ADR_W  = 5
);
  logic [ADR_W-1:0]  adr_i;
  logic              reg_write_en;
  logic              reg_read_en;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;

  modport master (
    output adr_i, reg_write_en, reg_read_en, data_i,
    input  data_o
  );

  modport slave (
    input  adr_i, reg_write_en, reg_read_en, data_i,
    output data_o
  );
endinterface

// File: rtl/sd_host_registers.sv
// sd_host_registers
//   Control/status register file of the SD host controller.
//   Ports:
//     clock, reset               system clock, asynchronous active-high reset
//     bus                        register access bus (slave side)
//     command_complete           one-cycle pulse from the command path
//     response_i                 command response, captured on command_complete
//     error/normal_interrupt_status_i  per-bit interrupt set pulses
//     block_size ... error_interrupt_status_o  register contents to the
//                                command and data paths
//   Reads return the addressed register zero-extended, one cycle after the
//   read strobe, and hold until the next read.
module sd_host_registers
  import sd_host_registers_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADR_W  = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  sd_host_registers_if.slave           bus,
  input  logic                         command_complete,
  input  logic [DATA_W-1:0]            response_i,
  input  logic [INT_STATUS_W-1:0]      error_interrupt_status_i,
  input  logic [INT_STATUS_W-1:0]      normal_interrupt_status_i,
  output logic [BLOCK_SIZE_W-1:0]      block_size,
  output logic [BLOCK_COUNT_W-1:0]     block_count,
  output logic [ARGUMENT_W-1:0]        argument,
  output logic [TRANSFER_MODE_W-1:0]   transfer_mode,
  output logic [COMMAND_W-1:0]         command,
  output logic [PRESENT_STATE_W-1:0]   present_state,
  output logic [TIMEOUT_CONTROL_W-1:0] timeout_control,
  output logic [SOFTWARE_RESET_W-1:0]  software_reset,
  output logic [INT_STATUS_W-1:0]      error_interrupt_status_o
);

  logic [BLOCK_SIZE_W-1:0]      block_size_q,      block_size_d;
  logic [BLOCK_COUNT_W-1:0]     block_count_q,     block_count_d;
  logic [ARGUMENT_W-1:0]        argument_q,        argument_d;
  logic [TRANSFER_MODE_W-1:0]   transfer_mode_q,   transfer_mode_d;
  logic [COMMAND_W-1:0]         command_q,         command_d;
  logic [DATA_W-1:0]            response_q,        response_d;
  logic                         cmd_inhibit_q,     cmd_inhibit_d;
  logic [TIMEOUT_CONTROL_W-1:0] timeout_control_q, timeout_control_d;
  logic [SOFTWARE_RESET_W-1:0]  software_reset_q,  software_reset_d;
  logic [INT_STATUS_W-1:0]      norm_int_q,        norm_int_d;
  logic [INT_STATUS_W-1:0]      err_int_q,         err_int_d;
  logic [DATA_W-1:0]            data_o_q,          data_o_d;

  logic [DATA_W-1:0]            rd_data;

  // Only the low ARGUMENT_W bits of write data reach any register.
  logic unused_data_hi;
  assign unused_data_hi = ^bus.data_i[DATA_W-1:ARGUMENT_W];

  // Write strobes per register
  logic wr_block_size, wr_block_count, wr_argument, wr_transfer_mode;
  logic wr_command, wr_timeout_control, wr_software_reset;
  logic wr_norm_int, wr_err_int;

  assign wr_block_size      = bus.reg_write_en && (bus.adr_i == REG_BLOCK_SIZE);
  assign wr_block_count     = bus.reg_write_en && (bus.adr_i == REG_BLOCK_COUNT);
  assign wr_argument        = bus.reg_write_en && (bus.adr_i == REG_ARGUMENT);
  assign wr_transfer_mode   = bus.reg_write_en && (bus.adr_i == REG_TRANSFER_MODE);
  assign wr_command         = bus.reg_write_en && (bus.adr_i == REG_COMMAND);
  assign wr_timeout_control = bus.reg_write_en && (bus.adr_i == REG_TIMEOUT_CONTROL);
  assign wr_software_reset  = bus.reg_write_en && (bus.adr_i == REG_SOFTWARE_RESET);
  assign wr_norm_int        = bus.reg_write_en && (bus.adr_i == REG_NORM_INT_STATUS);
  assign wr_err_int         = bus.reg_write_en && (bus.adr_i == REG_ERR_INT_STATUS);

  // Read mux works on current register values, so a read that coincides
  // with a write to the same address returns the pre-write contents.
  always_comb begin
    rd_data = '0;
    case (bus.adr_i)
      REG_BLOCK_SIZE:      rd_data = DATA_W'(block_size_q);
      REG_BLOCK_COUNT:     rd_data = DATA_W'(block_count_q);
      REG_ARGUMENT:        rd_data = DATA_W'(argument_q);
      REG_TRANSFER_MODE:   rd_data = DATA_W'(transfer_mode_q);
      REG_COMMAND:         rd_data = DATA_W'(command_q);
      REG_RESPONSE:        rd_data = response_q;
      REG_PRESENT_STATE:   rd_data = DATA_W'(present_state);
      REG_TIMEOUT_CONTROL: rd_data = DATA_W'(timeout_control_q);
      REG_SOFTWARE_RESET:  rd_data = DATA_W'(software_reset_q);
      REG_NORM_INT_STATUS: rd_data = DATA_W'(norm_int_q);
      REG_ERR_INT_STATUS:  rd_data = DATA_W'(err_int_q);
      default:             rd_data = '0;
    endcase
  end

  always_comb begin
    block_size_d      = block_size_q;
    block_count_d     = block_count_q;
    argument_d        = argument_q;
    transfer_mode_d   = transfer_mode_q;
    command_d         = command_q;
    response_d        = response_q;
    cmd_inhibit_d     = cmd_inhibit_q;
    timeout_control_d = timeout_control_q;
    data_o_d          = data_o_q;

    if (wr_block_size)      block_size_d      = bus.data_i[BLOCK_SIZE_W-1:0];
    if (wr_block_count)     block_count_d     = bus.data_i[BLOCK_COUNT_W-1:0];
    if (wr_argument)        argument_d        = bus.data_i[ARGUMENT_W-1:0];
    if (wr_transfer_mode)   transfer_mode_d   = bus.data_i[TRANSFER_MODE_W-1:0];
    if (wr_command)         command_d         = bus.data_i[COMMAND_W-1:0];
    if (wr_timeout_control) timeout_control_d = bus.data_i[TIMEOUT_CONTROL_W-1:0];

    if (command_complete) response_d = response_i;

    // Issuing a new command outranks completion of the previous one: the
    // inhibit must stay up for the command just written.
    if (wr_command)            cmd_inhibit_d = 1'b1;
    else if (command_complete) cmd_inhibit_d = 1'b0;

    norm_int_d = w1c_next(norm_int_q,
                          wr_norm_int ? bus.data_i[INT_STATUS_W-1:0] : '0,
                          normal_interrupt_status_i |
                            {{(INT_STATUS_W-1){1'b0}}, command_complete});
    err_int_d  = w1c_next(err_int_q,
                          wr_err_int ? bus.data_i[INT_STATUS_W-1:0] : '0,
                          error_interrupt_status_i);

    if (bus.reg_read_en) data_o_d = rd_data;

    // Written bits live for exactly one cycle.
    software_reset_d = wr_software_reset ? bus.data_i[SOFTWARE_RESET_W-1:0] : '0;

    // Reset-all: the cycle after the bit is seen, everything except
    // software_reset itself behaves as if the reset port had fired.
    if (software_reset_q[SWRST_ALL_BIT]) begin
      block_size_d      = '0;
      block_count_d     = '0;
      argument_d        = '0;
      transfer_mode_d   = '0;
      command_d         = '0;
      response_d        = '0;
      cmd_inhibit_d     = 1'b0;
      timeout_control_d = '0;
      norm_int_d        = '0;
      err_int_d         = '0;
      data_o_d          = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      block_size_q      <= '0;
      block_count_q     <= '0;
      argument_q        <= '0;
      transfer_mode_q   <= '0;
      command_q         <= '0;
      response_q        <= '0;
      cmd_inhibit_q     <= 1'b0;
      timeout_control_q <= '0;
      software_reset_q  <= '0;
      norm_int_q        <= '0;
      err_int_q         <= '0;
      data_o_q          <= '0;
    end else begin
      block_size_q      <= block_size_d;
      block_count_q     <= block_count_d;
      argument_q        <= argument_d;
      transfer_mode_q   <= transfer_mode_d;
      command_q         <= command_d;
      response_q        <= response_d;
      cmd_inhibit_q     <= cmd_inhibit_d;
      timeout_control_q <= timeout_control_d;
      software_reset_q  <= software_reset_d;
      norm_int_q        <= norm_int_d;
      err_int_q         <= err_int_d;
      data_o_q          <= data_o_d;
    end
  end

  assign block_size               = block_size_q;
  assign block_count              = block_count_q;
  assign argument                 = argument_q;
  assign transfer_mode            = transfer_mode_q;
  assign command                  = command_q;
  assign present_state            = {{(PRESENT_STATE_W-1){1'b0}}, cmd_inhibit_q};
  assign timeout_control          = timeout_control_q;
  assign software_reset           = software_reset_q;
  assign error_interrupt_status_o = err_int_q;
  assign bus.data_o               = data_o_q;

endmodule

// File: tb/tb_sd_host_registers.sv
module tb_sd_host_registers;
  import sd_host_registers_pkg::*;

  logic         clock;
  logic         reset;
  logic         command_complete;
  logic [127:0] response_i;
  logic [15:0]  error_interrupt_status_i;
  logic [15:0]  normal_interrupt_status_i;
  logic [11:0]  block_size;
  logic [15:0]  block_count;
  logic [31:0]  argument;
  logic [15:0]  transfer_mode;
  logic [15:0]  command;
  logic [15:0]  present_state;
  logic [15:0]  timeout_control;
  logic [2:0]   software_reset;
  logic [15:0]  error_interrupt_status_o;

  int n_checks = 0;
  int n_fail   = 0;

  sd_host_registers_if #(.DATA_W(128), .ADR_W(5)) bus_if ();

  sd_host_registers #(.DATA_W(128), .ADR_W(5)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .bus                       (bus_if),
    .command_complete          (command_complete),
    .response_i                (response_i),
    .error_interrupt_status_i  (error_interrupt_status_i),
    .normal_interrupt_status_i (normal_interrupt_status_i),
    .block_size                (block_size),
    .block_count               (block_count),
    .argument                  (argument),
    .transfer_mode             (transfer_mode),
    .command                   (command),
    .present_state             (present_state),
    .timeout_control           (timeout_control),
    .software_reset            (software_reset),
    .error_interrupt_status_o  (error_interrupt_status_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [4:0] adr, input logic [127:0] data);
    bus_if.adr_i        = adr;
    bus_if.data_i       = data;
    bus_if.reg_write_en = 1'b1;
    tick();
    bus_if.reg_write_en = 1'b0;
    $display("write adr=%h data=%h", adr, data[31:0]);
  endtask

  task automatic do_read(input logic [4:0] adr);
    bus_if.adr_i       = adr;
    bus_if.reg_read_en = 1'b1;
    tick();
    bus_if.reg_read_en = 1'b0;
    $display("read  adr=%h data=%h", adr, bus_if.data_o);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (block_size !== 12'h0) begin n_fail++; $display("FAIL reset_block_size got %h want 000", block_size); end
    n_checks++; if (argument !== 32'h0) begin n_fail++; $display("FAIL reset_argument got %h want 0", argument); end
    n_checks++; if (present_state !== 16'h0) begin n_fail++; $display("FAIL reset_present_state got %h want 0", present_state); end
    n_checks++; if (software_reset !== 3'h0) begin n_fail++; $display("FAIL reset_software_reset got %h want 0", software_reset); end
    n_checks++; if (error_interrupt_status_o !== 16'h0) begin n_fail++; $display("FAIL reset_err_int got %h want 0", error_interrupt_status_o); end
    n_checks++; if (bus_if.data_o !== 128'h0) begin n_fail++; $display("FAIL reset_data_o got %h want 0", bus_if.data_o); end
    reset = 1'b0;
    tick();
    do_read(5'h06);
    n_checks++; if (bus_if.data_o !== 128'h0) begin n_fail++; $display("FAIL read_present_state got %h want 0", bus_if.data_o); end
  endtask

  task automatic test_rw();
    do_write(5'h02, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEADBEEF});
    n_checks++; if (argument !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_argument got %h want deadbeef", argument); end
    do_read(5'h02);
    n_checks++; if (bus_if.data_o !== 128'hDEADBEEF) begin n_fail++; $display("FAIL read_argument got %h want deadbeef", bus_if.data_o); end
    tick();
    tick();
    n_checks++; if (bus_if.data_o !== 128'hDEADBEEF) begin n_fail++; $display("FAIL data_o_hold got %h want deadbeef", bus_if.data_o); end
    do_write(5'h00, 128'hFFFF);
    n_checks++; if (block_size !== 12'hFFF) begin n_fail++; $display("FAIL block_size_trunc got %h want fff", block_size); end
    do_read(5'h00);
    n_checks++; if (bus_if.data_o !== 128'hFFF) begin n_fail++; $display("FAIL read_block_size got %h want fff", bus_if.data_o); end
    do_write(5'h06, 128'h1234);
    n_checks++; if (present_state !== 16'h0) begin n_fail++; $display("FAIL ro_present_state got %h want 0", present_state); end
    do_write(5'h01, 128'h1_ABCD);
    do_write(5'h03, 128'h0033);
    do_write(5'h07, 128'h000E);
    n_checks++; if (block_count !== 16'hABCD) begin n_fail++; $display("FAIL block_count got %h want abcd", block_count); end
    n_checks++; if (transfer_mode !== 16'h0033) begin n_fail++; $display("FAIL transfer_mode got %h want 0033", transfer_mode); end
    n_checks++; if (timeout_control !== 16'h000E) begin n_fail++; $display("FAIL timeout_control got %h want 000e", timeout_control); end
    do_write(5'h1F, 128'h5555);
    do_read(5'h1F);
    n_checks++; if (bus_if.data_o !== 128'h0) begin n_fail++; $display("FAIL read_unmapped got %h want 0", bus_if.data_o); end
  endtask

  task automatic test_read_during_write();
    bus_if.adr_i        = 5'h07;
    bus_if.data_i       = 128'h0777;
    bus_if.reg_write_en = 1'b1;
    bus_if.reg_read_en  = 1'b1;
    tick();
    bus_if.reg_write_en = 1'b0;
    bus_if.reg_read_en  = 1'b0;
    $display("rdwr  adr=07 data=0777 read=%h", bus_if.data_o);
    n_checks++; if (bus_if.data_o !== 128'h000E) begin n_fail++; $display("FAIL rdwr_old_value got %h want 000e", bus_if.data_o); end
    n_checks++; if (timeout_control !== 16'h0777) begin n_fail++; $display("FAIL rdwr_new_value got %h want 0777", timeout_control); end
  endtask

  task automatic test_command();
    logic [127:0] resp;
    resp = {4{32'hA5A5A5A5}};
    do_write(5'h04, 128'h0011);
    n_checks++; if (command !== 16'h0011) begin n_fail++; $display("FAIL command got %h want 0011", command); end
    n_checks++; if (present_state !== 16'h0001) begin n_fail++; $display("FAIL inhibit_set got %h want 0001", present_state); end
    command_complete = 1'b1;
    response_i       = resp;
    tick();
    command_complete = 1'b0;
    response_i       = '0;
    $display("cmd_complete response=%h", resp);
    n_checks++; if (present_state !== 16'h0000) begin n_fail++; $display("FAIL inhibit_clear got %h want 0000", present_state); end
    do_read(5'h05);
    n_checks++; if (bus_if.data_o !== resp) begin n_fail++; $display("FAIL read_response got %h want %h", bus_if.data_o, resp); end
    do_read(5'h09);
    n_checks++; if (bus_if.data_o !== 128'h1) begin n_fail++; $display("FAIL norm_int_cc got %h want 1", bus_if.data_o); end
    // Command write coincident with completion keeps the inhibit set.
    command_complete = 1'b1;
    do_write(5'h04, 128'h0022);
    command_complete = 1'b0;
    n_checks++; if (present_state !== 16'h0001) begin n_fail++; $display("FAIL inhibit_collision got %h want 0001", present_state); end
    do_write(5'h09, 128'h0001);
    do_read(5'h09);
    n_checks++; if (bus_if.data_o !== 128'h0) begin n_fail++; $display("FAIL norm_int_w1c got %h want 0", bus_if.data_o); end
  endtask

  task automatic test_interrupts();
    error_interrupt_status_i = 16'h0004;
    tick();
    error_interrupt_status_i = 16'h0000;
    $display("err_pulse 0004");
    n_checks++; if (error_interrupt_status_o !== 16'h0004) begin n_fail++; $display("FAIL err_set got %h want 0004", error_interrupt_status_o); end
    error_interrupt_status_i = 16'h0004;
    do_write(5'h0A, 128'h0004);
    error_interrupt_status_i = 16'h0000;
    n_checks++; if (error_interrupt_status_o !== 16'h0004) begin n_fail++; $display("FAIL err_set_wins got %h want 0004", error_interrupt_status_o); end
    do_write(5'h0A, 128'h0004);
    n_checks++; if (error_interrupt_status_o !== 16'h0000) begin n_fail++; $display("FAIL err_clear got %h want 0000", error_interrupt_status_o); end
    error_interrupt_status_i = 16'h8001;
    tick();
    error_interrupt_status_i = 16'h0000;
    do_write(5'h0A, 128'h0001);
    n_checks++; if (error_interrupt_status_o !== 16'h8000) begin n_fail++; $display("FAIL err_partial_clear got %h want 8000", error_interrupt_status_o); end
    normal_interrupt_status_i = 16'h0010;
    tick();
    normal_interrupt_status_i = 16'h0000;
    do_read(5'h09);
    n_checks++; if (bus_if.data_o !== 128'h0010) begin n_fail++; $display("FAIL norm_int_set got %h want 0010", bus_if.data_o); end
  endtask

  task automatic test_soft_reset();
    do_write(5'h02, 128'h1234_5678);
    do_write(5'h00, 128'h0200);
    do_write(5'h08, 128'h1);
    n_checks++; if (software_reset !== 3'b001) begin n_fail++; $display("FAIL swrst_pulse got %h want 1", software_reset); end
    n_checks++; if (argument !== 32'h1234_5678) begin n_fail++; $display("FAIL swrst_not_yet got %h want 12345678", argument); end
    tick();
    n_checks++; if (software_reset !== 3'b000) begin n_fail++; $display("FAIL swrst_autoclear got %h want 0", software_reset); end
    n_checks++; if (argument !== 32'h0) begin n_fail++; $display("FAIL swrst_argument got %h want 0", argument); end
    n_checks++; if (block_size !== 12'h0) begin n_fail++; $display("FAIL swrst_block_size got %h want 0", block_size); end
    n_checks++; if (timeout_control !== 16'h0) begin n_fail++; $display("FAIL swrst_timeout got %h want 0", timeout_control); end
    n_checks++; if (present_state !== 16'h0) begin n_fail++; $display("FAIL swrst_present_state got %h want 0", present_state); end
    n_checks++; if (error_interrupt_status_o !== 16'h0) begin n_fail++; $display("FAIL swrst_err_int got %h want 0", error_interrupt_status_o); end
    do_read(5'h05);
    n_checks++; if (bus_if.data_o !== 128'h0) begin n_fail++; $display("FAIL swrst_response got %h want 0", bus_if.data_o); end
    do_read(5'h09);
    n_checks++; if (bus_if.data_o !== 128'h0) begin n_fail++; $display("FAIL swrst_norm_int got %h want 0", bus_if.data_o); end
    // Bits 1 and 2 pulse the output only.
    do_write(5'h02, 128'hCAFE);
    do_write(5'h08, 128'h6);
    n_checks++; if (software_reset !== 3'b110) begin n_fail++; $display("FAIL swrst_bits12 got %h want 6", software_reset); end
    tick();
    n_checks++; if (software_reset !== 3'b000) begin n_fail++; $display("FAIL swrst_bits12_clear got %h want 0", software_reset); end
    n_checks++; if (argument !== 32'hCAFE) begin n_fail++; $display("FAIL swrst_bits12_keep got %h want cafe", argument); end
  endtask

  task automatic test_async_reset();
    do_write(5'h00, 128'h0123);
    do_write(5'h02, 128'h5A5A_5A5A);
    do_read(5'h02);
    bus_if.adr_i        = 5'h02;
    bus_if.data_i       = 128'h1111_2222;
    bus_if.reg_write_en = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    $display("async reset mid-write");
    n_checks++; if (argument !== 32'h0) begin n_fail++; $display("FAIL async_argument got %h want 0", argument); end
    n_checks++; if (block_size !== 12'h0) begin n_fail++; $display("FAIL async_block_size got %h want 0", block_size); end
    n_checks++; if (bus_if.data_o !== 128'h0) begin n_fail++; $display("FAIL async_data_o got %h want 0", bus_if.data_o); end
    tick();
    bus_if.reg_write_en = 1'b0;
    n_checks++; if (argument !== 32'h0) begin n_fail++; $display("FAIL async_abort got %h want 0", argument); end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset                     = 1'b1;
    command_complete          = 1'b0;
    response_i                = '0;
    error_interrupt_status_i  = '0;
    normal_interrupt_status_i = '0;
    bus_if.adr_i              = '0;
    bus_if.data_i             = '0;
    bus_if.reg_write_en       = 1'b0;
    bus_if.reg_read_en        = 1'b0;

    test_reset();
    test_rw();
    test_read_during_write();
    test_command();
    test_interrupts();
    test_soft_reset();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_host_registers.md
Name: sd_host_registers

Overview:
- Memory-mapped control/status register file of the SD host controller.
- Sits behind the Wishbone slave: the slave drives the address, write data and one-cycle read/write enables.
- Register outputs drive the command and data paths.
- Captures command responses, interrupt status and command-complete events from the SD side.

Parameters:
- DATA_W, 128, width of the data_i, response_i and data_o buses.
- ADR_W, 5, register word-address width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all registers.
- adr_i  in  5  register word address.
- reg_write_en  in  1  write strobe; one cycle per access.
- reg_read_en  in  1  read strobe; one cycle per access.
- command_complete  in  1  one-cycle pulse from the command path.
- data_i  in  128  write data; the register uses its low bits.
- response_i  in  128  SD command response.
- error_interrupt_status_i  in  16  error event pulses; bit-wise set sources.
- normal_interrupt_status_i  in  16  normal event pulses; bit-wise set sources.
- block_size  out  12  register 0x00.
- block_count  out  16  register 0x01.
- argument  out  32  register 0x02.
- transfer_mode  out  16  register 0x03.
- command  out  16  register 0x04.
- present_state  out  16  register 0x06, read-only.
- timeout_control  out  16  register 0x07.
- software_reset  out  3  register 0x08.
- error_interrupt_status_o  out  16  register 0x0A.
- data_o  out  128  read data.

Behaviour:
Address map:
- 0x00 block_size, RW.
- 0x01 block_count, RW.
- 0x02 argument, RW.
- 0x03 transfer_mode, RW.
- 0x04 command, RW.
- 0x05 response, RO, 128 bits.
- 0x06 present_state, RO.
- 0x07 timeout_control, RW.
- 0x08 software_reset, RW, self-clearing.
- 0x09 normal_interrupt_status, RW1C.
- 0x0A error_interrupt_status, RW1C.
- Writes to RO or unmapped addresses are ignored. Reads of unmapped addresses return 0.

Reset:
- All registers are 0, data_o is 0, software_reset is 0.

Write:
- When reg_write_en=1, the addressed RW register loads data_i[width-1:0] at the next edge. Upper data_i bits are ignored.

Read:
- When reg_read_en=1, data_o loads the addressed register, zero-extended to 128 bits, at the next edge.
- Latency is 1 cycle; data_o holds its value until the next read.
- A read and a write to the same address in the same cycle returns the old value.

command register:
- A write to 0x04 sets present_state[0] (command inhibit).
- command_complete=1 clears present_state[0] and loads response_i into the response register.
- Other present_state bits read 0.
- If a command write and command_complete occur in the same cycle, present_state[0] ends at 1.

Interrupt status registers:
- Each cycle: status <= (status & ~clear_mask) | set_in.
- clear_mask = data_i[15:0] when writing that register, else 0.
- set_in = the matching *_interrupt_status_i input. For the normal register, command_complete is also ORed into bit 0.
- If a set and a clear hit the same bit in the same cycle, the set wins.

software_reset:
- Written bits are asserted for exactly one cycle, then auto-clear.
- bit0 (reset all): on the following cycle, every RW/RO register except software_reset returns to its reset value, identical to the reset port.
- bits 1 and 2 are outputs only.

Asynchronous reset:
- Reset asserted mid-access aborts the access.
- Outputs go to 0 immediately, with no clock required.

Decomposition:
- Shared package/include: register address constants (REG_BLOCK_SIZE=5'h00 … REG_ERR_INT_STATUS=5'h0A) and register widths.
- Used by this block and the Wishbone slave.
- Single module; no sub-module needed.
- The W1C status logic may be a small generic function or generated block.

Test Plan:
- Reset -> all outputs are 0. Then read 0x06 -> data_o=0 one cycle later.
- Write 0x02 with data_i=0x...DEADBEEF -> argument=32'hDEADBEEF.
  - Read 0x02 -> data_o=128'h0000_..._DEADBEEF after 1 cycle.
- Write 0x00 with 0xFFFF -> block_size=12'hFFF.
  - Write 0x06 with 0x1234 -> present_state unchanged (0).
- Write command=0x0011 -> present_state[0]=1.
  - Pulse command_complete with response_i=128'hA5… -> present_state[0]=0.
  - Read 0x05 -> data_o=128'hA5…
  - Read 0x09 -> bit0=1.
- Pulse error_interrupt_status_i=0x0004 -> error_interrupt_status_o=0x0004.
  - Write 0x0A with 0x0004 while pulsing 0x0004 again -> stays 0x0004.
  - Write 0x0A with 0x0004 alone -> 0x0000.
- Write software_reset=3'b001 after loading several registers -> software_reset=1 for one cycle.
  - All registers 0 the next cycle.
  - Asynchronous reset mid-write clears immediately.
